// File: rtl/bp_stream_nbf_loader_gen.sv
// bp_stream_nbf_loader_gen: deserialises NBF records from a host stream into I/O write commands,
// with optional memory-clear sweep, fence, per-core unfreeze sweep and sticky error reporting.
module bp_stream_nbf_loader_gen #(
   parameter int stream_data_width_p = 32,
   parameter int nbf_opcode_width_p = 8,
   parameter int nbf_addr_width_p = 40,
   parameter int nbf_data_width_p = 64,
   parameter int max_credits_p = 16,
   parameter bit clear_en_p = 1,
   parameter logic [nbf_addr_width_p-1:0] clear_base_p = 40'h80_0000_0000,
   parameter logic [nbf_addr_width_p-1:0] clear_limit_p = 40'h80_0400_0000,
   parameter int clear_stride_p = 8,
   parameter int num_core_p = 1,
   parameter bit unfreeze_en_p = 0,
   parameter logic [nbf_addr_width_p-1:0] freeze_base_p = 40'h00_0020_0008,
   parameter logic [nbf_addr_width_p-1:0] freeze_stride_p = 40'h00_0100_0000
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   output logic                           done_o,
   output logic                           error_o,
   output logic [nbf_addr_width_p-1:0]    io_cmd_addr_o,
   output logic [1:0]                     io_cmd_size_o,
   output logic [nbf_data_width_p-1:0]    io_cmd_data_o,
   output logic                           io_cmd_v_o,
   input  logic                           io_cmd_yumi_i,
   input  logic                           io_resp_v_i,
   output logic                           io_resp_ready_o,
   input  logic                           stream_v_i,
   input  logic [stream_data_width_p-1:0] stream_data_i,
   output logic                           stream_ready_o
);
   localparam int ow_lp = nbf_opcode_width_p;
   localparam int aw_lp = nbf_addr_width_p;
   localparam int dw_lp = nbf_data_width_p;
   localparam int rec_w_lp = ow_lp + aw_lp + dw_lp;
   localparam int flits_lp = (rec_w_lp + stream_data_width_p - 1) / stream_data_width_p;
   localparam int fcnt_w_lp = $clog2(flits_lp + 1);
   localparam int cred_w_lp = $clog2(max_credits_p + 1);
   localparam int core_w_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;
   localparam logic [1:0] clr_size_lp = 2'($clog2(clear_stride_p));

   typedef enum logic [2:0] {e_clear, e_load, e_fence, e_unfreeze, e_done} state_e;
   state_e state_r, state_n;

   logic [flits_lp*stream_data_width_p-1:0] sipo_r;
   logic [fcnt_w_lp-1:0] fcnt_r;
   logic [cred_w_lp-1:0] cred_r;
   logic [aw_lp-1:0] clr_addr_r, frz_addr_r;
   logic [core_w_lp-1:0] core_r;
   logic err_r, full, accept, pop, is_wr, is_fence, is_finish, bad_op, cred_ok;
   logic [ow_lp-1:0] opcode;
   logic [aw_lp-1:0] rec_addr, cmd_addr;
   logic [dw_lp-1:0] rec_data, cmd_data;
   logic [1:0] cmd_size;
   logic cmd_v, unused_pad;

   assign full = fcnt_r == fcnt_w_lp'(flits_lp);
   assign opcode = sipo_r[rec_w_lp-1 -: ow_lp];
   assign rec_addr = sipo_r[dw_lp +: aw_lp];
   assign rec_data = sipo_r[dw_lp-1:0];
   assign unused_pad = ^sipo_r;
   assign is_wr = opcode <= ow_lp'(3);
   assign is_fence = opcode == ow_lp'(8'hFE);
   assign is_finish = opcode == ow_lp'(8'hFF);
   assign bad_op = state_r == e_load && full && !is_wr && !is_fence && !is_finish;
   assign pop = state_r == e_load && full && (is_wr ? io_cmd_yumi_i : 1'b1);
   assign accept = stream_v_i && stream_ready_o;
   assign cred_ok = cred_r != cred_w_lp'(max_credits_p);

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_r <= clear_en_p ? e_clear : e_load;
         fcnt_r <= '0;
         sipo_r <= '0;
         cred_r <= '0;
         err_r <= 1'b0;
         clr_addr_r <= clear_base_p;
         frz_addr_r <= freeze_base_p;
         core_r <= '0;
      end else begin
         state_r <= state_n;
         if (accept) sipo_r[int'(fcnt_r)*stream_data_width_p +: stream_data_width_p] <= stream_data_i;
         fcnt_r <= pop ? '0 : accept ? fcnt_r + fcnt_w_lp'(1) : fcnt_r;
         // a response with nothing outstanding is a protocol error; the count saturates at 0
         if (io_cmd_yumi_i && !io_resp_v_i) cred_r <= cred_r + cred_w_lp'(1);
         else if (io_resp_v_i && !io_cmd_yumi_i && cred_r != '0) cred_r <= cred_r - cred_w_lp'(1);
         if ((io_resp_v_i && cred_r == '0) || bad_op) err_r <= 1'b1;
         if (state_r == e_clear && io_cmd_yumi_i) clr_addr_r <= clr_addr_r + aw_lp'(clear_stride_p);
         if (state_r == e_unfreeze && io_cmd_yumi_i) begin
            frz_addr_r <= frz_addr_r + freeze_stride_p;
            core_r <= core_r + core_w_lp'(1);
         end
      end
   end

   always_comb begin
      state_n = state_r;
      case (state_r)
         e_clear: if (io_cmd_yumi_i && clr_addr_r == clear_limit_p) state_n = e_load;
         e_load: if (full && is_fence) state_n = e_fence;
            else if (full && is_finish) state_n = unfreeze_en_p ? e_unfreeze : e_done;
         e_fence: if (cred_r == '0) state_n = e_load;
         e_unfreeze: if (io_cmd_yumi_i && core_r == core_w_lp'(num_core_p - 1)) state_n = e_done;
         default: state_n = state_r;
      endcase
   end

   always_comb begin
      cmd_v = 1'b0;
      cmd_addr = rec_addr;
      cmd_data = rec_data;
      cmd_size = opcode[1:0];
      case (state_r)
         e_clear: begin
            cmd_v = 1'b1;
            cmd_addr = clr_addr_r;
            cmd_data = '0;
            cmd_size = clr_size_lp;
         end
         e_load: cmd_v = full && is_wr;
         e_unfreeze: begin
            cmd_v = 1'b1;
            cmd_addr = frz_addr_r;
            cmd_data = '0;
            cmd_size = 2'd3;
         end
         default: cmd_v = 1'b0;
      endcase
   end

   // outputs are held at their reset values for as long as reset is applied
   assign io_cmd_v_o = reset_n_i && cmd_v && cred_ok;
   assign io_cmd_addr_o = reset_n_i ? cmd_addr : '0;
   assign io_cmd_data_o = reset_n_i ? cmd_data : '0;
   assign io_cmd_size_o = reset_n_i ? cmd_size : '0;
   assign stream_ready_o = reset_n_i && !full && (state_r == e_load || state_r == e_clear);
   assign done_o = reset_n_i && state_r == e_done && cred_r == '0;
   assign error_o = reset_n_i && err_r;
   assign io_resp_ready_o = 1'b1;
endmodule

// File: tb/tb_bp_stream_nbf_loader_gen.sv
// tb_bp_stream_nbf_loader_gen: directed checks of clear sweep, writes, credits, fence, errors, unfreeze and reset
`define CHK(t, g, e) chk(t, 64'(g), 64'(e))
module tb_bp_stream_nbf_loader_gen;
   logic clk = 1'b0, reset_n, done, error, cmd_v, yumi, resp_v, resp_ready, stream_v, stream_ready;
   logic [39:0] addr, stream_data;
   logic [1:0] size;
   logic [63:0] data;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   bp_stream_nbf_loader_gen #(
      .stream_data_width_p(40), .max_credits_p(2), .clear_en_p(1'b1),
      .clear_base_p(40'h100), .clear_limit_p(40'h118), .clear_stride_p(8),
      .num_core_p(3), .unfreeze_en_p(1'b1)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n), .done_o(done), .error_o(error),
      .io_cmd_addr_o(addr), .io_cmd_size_o(size), .io_cmd_data_o(data),
      .io_cmd_v_o(cmd_v), .io_cmd_yumi_i(yumi), .io_resp_v_i(resp_v),
      .io_resp_ready_o(resp_ready), .stream_v_i(stream_v), .stream_data_i(stream_data),
      .stream_ready_o(stream_ready)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] op, input logic [39:0] a, input logic [63:0] d);
      logic [119:0] r;
      int n;
      r = {8'h00, op, a, d};
      for (int i = 0; i < 3; i++) begin
         n = 0;
         stream_v = 1'b1;
         stream_data = r[i*40 +: 40];
         while (!stream_ready && n < 20) begin
            step();
            n++;
         end
         `CHK("flit_ready_wait", n < 20, 1);
         step();
         stream_v = 1'b0;
         if (i == 0) repeat ($urandom_range(1, 3)) step();
      end
   endtask

   task automatic run_clear();
      for (int k = 0; k < 4; k++) begin
         checks += 4;
         if (cmd_v !== 1'b1) begin errors++; $error("FAIL clr_v k=%0d got %0h", k, cmd_v); end
         if (addr !== 40'h100 + 40'(8 * k)) begin errors++; $error("FAIL clr_addr k=%0d got %0h", k, addr); end
         if (data !== 64'h0) begin errors++; $error("FAIL clr_data k=%0d got %0h", k, data); end
         if (size !== 2'd3) begin errors++; $error("FAIL clr_size k=%0d got %0h", k, size); end
         yumi = 1'b1;
         resp_v = k > 0;
         step();
      end
      yumi = 1'b0;
      resp_v = 1'b1;
      `CHK("clr_end_v", cmd_v, 0);
      `CHK("clr_end_ready", stream_ready, 1);
      step();
      resp_v = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; yumi = 1'b0; resp_v = 1'b0; stream_v = 1'b0; stream_data = '0;
      step();
      step();
      `CHK("rst_v", cmd_v, 0);
      `CHK("rst_ready", stream_ready, 0);
      `CHK("rst_done", done, 0);
      `CHK("rst_error", error, 0);
      `CHK("rst_resp_ready", resp_ready, 1);
      `CHK("rst_addr", addr, 0);
      reset_n = 1'b1;
      #1;
      run_clear();
      send(8'h02, 40'h80000004, 64'hDEADBEEF);
      `CHK("wr_v", cmd_v, 1);
      `CHK("wr_size", size, 2);
      `CHK("wr_addr", addr, 40'h80000004);
      `CHK("wr_data", data, 64'hDEADBEEF);
      yumi = 1'b1; step(); yumi = 1'b0;
      `CHK("wr_popped", cmd_v, 0);
      `CHK("wr_done_early", done, 0);
      send(8'h03, 40'h200, 64'h1111);
      `CHK("cr_b_v", cmd_v, 1);
      `CHK("cr_b_addr", addr, 40'h200);
      yumi = 1'b1; step(); yumi = 1'b0;
      send(8'h01, 40'h300, 64'h2222);
      `CHK("cr_stall_v", cmd_v, 0);
      step();
      `CHK("cr_stall_v2", cmd_v, 0);
      resp_v = 1'b1; step(); resp_v = 1'b0;
      `CHK("cr_release_v", cmd_v, 1);
      `CHK("cr_release_addr", addr, 40'h300);
      `CHK("cr_release_size", size, 1);
      yumi = 1'b1; step(); yumi = 1'b0;
      resp_v = 1'b1; step(); step(); resp_v = 1'b0;
      send(8'h00, 40'h400, 64'hAB);
      `CHK("fe_w_v", cmd_v, 1);
      `CHK("fe_w_size", size, 0);
      yumi = 1'b1; step(); yumi = 1'b0;
      send(8'hFE, 40'h0, 64'h0);
      `CHK("fe_not_issued", cmd_v, 0);
      step();
      `CHK("fe_ready", stream_ready, 0);
      step();
      `CHK("fe_hold_ready", stream_ready, 0);
      resp_v = 1'b1; step(); resp_v = 1'b0;
      `CHK("fe_zero_ready", stream_ready, 0);
      step();
      `CHK("fe_back_ready", stream_ready, 1);
      send(8'h03, 40'h500, 64'h55);
      `CHK("fe_e_v", cmd_v, 1);
      `CHK("fe_e_addr", addr, 40'h500);
      yumi = 1'b1; step(); yumi = 1'b0;
      resp_v = 1'b1; step(); resp_v = 1'b0;
      `CHK("err_clean", error, 0);
      send(8'h7A, 40'h600, 64'h1);
      `CHK("err_op_v", cmd_v, 0);
      step();
      `CHK("err_op_flag", error, 1);
      `CHK("err_op_ready", stream_ready, 1);
      resp_v = 1'b1; step(); resp_v = 1'b0;
      `CHK("err_sticky", error, 1);
      send(8'h02, 40'h700, 64'hCAFE);
      `CHK("err_next_v", cmd_v, 1);
      `CHK("err_next_addr", addr, 40'h700);
      `CHK("err_next_data", data, 64'hCAFE);
      yumi = 1'b1; step(); yumi = 1'b0;
      resp_v = 1'b1; step(); resp_v = 1'b0;
      send(8'hFF, 40'h0, 64'h0);
      `CHK("fin_v", cmd_v, 0);
      step();
      `CHK("unf0_v", cmd_v, 1);
      `CHK("unf0_addr", addr, 40'h20_0008);
      `CHK("unf0_size", size, 3);
      `CHK("unf0_data", data, 0);
      yumi = 1'b1; step(); yumi = 1'b0;
      `CHK("unf1_addr", addr, 40'h120_0008);
      yumi = 1'b1; step(); yumi = 1'b0;
      `CHK("unf_stall_v", cmd_v, 0);
      resp_v = 1'b1; step(); resp_v = 1'b0;
      `CHK("unf2_v", cmd_v, 1);
      `CHK("unf2_addr", addr, 40'h220_0008);
      yumi = 1'b1; step(); yumi = 1'b0;
      `CHK("dn_v", cmd_v, 0);
      `CHK("dn_ready", stream_ready, 0);
      `CHK("dn_done_early", done, 0);
      resp_v = 1'b1; step();
      `CHK("dn_done_one_left", done, 0);
      step(); resp_v = 1'b0;
      `CHK("dn_done", done, 1);
      step();
      `CHK("dn_done_hold", done, 1);
      `CHK("dn_error_sticky", error, 1);
      reset_n = 1'b0; step(); reset_n = 1'b1; #1;
      `CHK("rs_error_cleared", error, 0);
      run_clear();
      send(8'hFF, 40'h0, 64'h0);
      step();
      `CHK("rs_unf0_addr", addr, 40'h20_0008);
      yumi = 1'b1; step(); yumi = 1'b0;
      reset_n = 1'b0; step();
      `CHK("mr_v", cmd_v, 0);
      `CHK("mr_addr", addr, 0);
      `CHK("mr_data", data, 0);
      `CHK("mr_size", size, 0);
      `CHK("mr_ready", stream_ready, 0);
      `CHK("mr_done", done, 0);
      `CHK("mr_error", error, 0);
      `CHK("mr_resp_ready", resp_ready, 1);
      reset_n = 1'b1; #1;
      `CHK("mr_restart_v", cmd_v, 1);
      `CHK("mr_restart_addr", addr, 40'h100);
      resp_v = 1'b1; step(); resp_v = 1'b0;
      `CHK("spur_error", error, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
